// File: rtl/fft_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer and its surroundings.
// The master side is the sequencer itself. The slave side is the UART receiver,
// the FFT datapath and the UART transmitter seen as one environment.
`timescale 1ns/1ps
interface fft_frame_sequencer_if #(
  parameter int DATA_LENGTH = 8,
  parameter int SEL_W       = 5
);
  logic                   i_rx_done;
  logic [DATA_LENGTH-1:0] i_rx_byte;
  logic                   o_fft_load;
  logic [DATA_LENGTH-1:0] o_fft_byte;
  logic                   o_fft_start;
  logic                   i_fft_done;
  logic [SEL_W-1:0]       o_sel;
  logic                   o_tx_en;
  logic                   o_tx_start;
  logic                   i_tx_done;
  logic                   o_busy;
  logic                   o_frame_done;
  logic                   o_err_timeout;
  logic                   o_rx_overrun;

  modport master (
    input  i_rx_done, i_rx_byte, i_fft_done, i_tx_done,
    output o_fft_load, o_fft_byte, o_fft_start, o_sel, o_tx_en, o_tx_start,
           o_busy, o_frame_done, o_err_timeout, o_rx_overrun
  );

  modport slave (
    output i_rx_done, i_rx_byte, i_fft_done, i_tx_done,
    input  o_fft_load, o_fft_byte, o_fft_start, o_sel, o_tx_en, o_tx_start,
           o_busy, o_frame_done, o_err_timeout, o_rx_overrun
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the 16-point FFT path.
// It collects one frame of received bytes into the FFT, starts the FFT and
// watches it against a timeout. It then walks the output byte mux through
// every result byte, one transmitter start/done handshake per byte.
// All outputs come straight from flops, so no input reaches an output combinationally.
`timescale 1ns/1ps
module fft_frame_sequencer #(
  parameter int FFT_SIZE    = 16,
  parameter int WORD_SIZE   = 16,
  parameter int DATA_LENGTH = 8,
  parameter int FFT_TIMEOUT = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  fft_frame_sequencer_if.master bus
);

  localparam int TX_BYTES = FFT_SIZE * WORD_SIZE / DATA_LENGTH;
  localparam int SEL_W    = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
  localparam int CNT_W    = $clog2(FFT_SIZE + 1);
  localparam int TMR_W    = (FFT_TIMEOUT > 1) ? $clog2(FFT_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FFT_SIZE - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(FFT_TIMEOUT - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(TX_BYTES - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, RUN, SEND, WAIT_TX} state_e;

  state_e                 state, state_nxt;
  logic [CNT_W-1:0]       byte_cnt, byte_cnt_nxt;
  logic [TMR_W-1:0]       tmr, tmr_nxt;
  logic                   fft_load, fft_load_nxt;
  logic [DATA_LENGTH-1:0] fft_byte, fft_byte_nxt;
  logic                   fft_start, fft_start_nxt;
  logic [SEL_W-1:0]       sel, sel_nxt;
  logic                   tx_en, tx_en_nxt;
  logic                   tx_start, tx_start_nxt;
  logic                   busy, busy_nxt;
  logic                   frame_done, frame_done_nxt;
  logic                   err_timeout, err_timeout_nxt;
  logic                   rx_overrun, rx_overrun_nxt;

  // Next-state and next-output decode; strobes default low, everything else holds.
  always_comb begin
    state_nxt       = state;
    byte_cnt_nxt    = byte_cnt;
    tmr_nxt         = tmr;
    fft_load_nxt    = 1'b0;
    fft_byte_nxt    = fft_byte;
    fft_start_nxt   = 1'b0;
    sel_nxt         = sel;
    tx_start_nxt    = 1'b0;
    frame_done_nxt  = 1'b0;
    err_timeout_nxt = err_timeout;
    rx_overrun_nxt  = rx_overrun;

    case (state)
      IDLE: begin
        if (bus.i_rx_done) begin
          fft_load_nxt    = 1'b1;
          fft_byte_nxt    = bus.i_rx_byte;
          byte_cnt_nxt    = CNT_W'(1);
          err_timeout_nxt = 1'b0;
          rx_overrun_nxt  = 1'b0;
          if (FFT_SIZE == 1) begin
            state_nxt     = RUN;
            fft_start_nxt = 1'b1;
            tmr_nxt       = '0;
          end else begin
            state_nxt = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (bus.i_rx_done) begin
          fft_load_nxt = 1'b1;
          fft_byte_nxt = bus.i_rx_byte;
          byte_cnt_nxt = byte_cnt + 1'b1;
          if (byte_cnt == LAST_BYTE) begin
            state_nxt     = RUN;
            fft_start_nxt = 1'b1;
            tmr_nxt       = '0;
          end
        end
      end
      RUN: begin
        if (bus.i_rx_done) rx_overrun_nxt = 1'b1;
        // A done arriving on the expiry cycle still counts as success.
        if (bus.i_fft_done) begin
          state_nxt = SEND;
          sel_nxt   = '0;
        end else if (tmr == TMR_LAST) begin
          state_nxt       = IDLE;
          err_timeout_nxt = 1'b1;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      SEND: begin
        if (bus.i_rx_done) rx_overrun_nxt = 1'b1;
        tx_start_nxt = 1'b1;
        state_nxt    = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.i_rx_done) rx_overrun_nxt = 1'b1;
        if (bus.i_tx_done) begin
          if (sel == SEL_LAST) begin
            frame_done_nxt = 1'b1;
            sel_nxt        = '0;
            state_nxt      = IDLE;
          end else begin
            sel_nxt   = sel + 1'b1;
            state_nxt = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    tx_en_nxt = (state_nxt == SEND) || (state_nxt == WAIT_TX);
    busy_nxt  = (state_nxt != IDLE);
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Counters and registered outputs, all cleared by reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      byte_cnt    <= '0;
      tmr         <= '0;
      fft_load    <= 1'b0;
      fft_byte    <= '0;
      fft_start   <= 1'b0;
      sel         <= '0;
      tx_en       <= 1'b0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      byte_cnt    <= byte_cnt_nxt;
      tmr         <= tmr_nxt;
      fft_load    <= fft_load_nxt;
      fft_byte    <= fft_byte_nxt;
      fft_start   <= fft_start_nxt;
      sel         <= sel_nxt;
      tx_en       <= tx_en_nxt;
      tx_start    <= tx_start_nxt;
      busy        <= busy_nxt;
      frame_done  <= frame_done_nxt;
      err_timeout <= err_timeout_nxt;
      rx_overrun  <= rx_overrun_nxt;
    end
  end

  assign bus.o_fft_load    = fft_load;
  assign bus.o_fft_byte    = fft_byte;
  assign bus.o_fft_start   = fft_start;
  assign bus.o_sel         = sel;
  assign bus.o_tx_en       = tx_en;
  assign bus.o_tx_start    = tx_start;
  assign bus.o_busy        = busy;
  assign bus.o_frame_done  = frame_done;
  assign bus.o_err_timeout = err_timeout;
  assign bus.o_rx_overrun  = rx_overrun;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer.
// Stimulus drives the inputs and feeds a frame-level reference model.
// The model pushes expected events (byte, and the cycle it must show up) into queues.
// An independent monitor pops those queues whenever the DUT raises an output event.
// Cycle labels: label k is the interval after rising edge k. An input driven in
// label k-1 is sampled at edge k, and a 1-cycle registered response shows in label k.
`timescale 1ns/1ps
module tb_fft_frame_sequencer;

  localparam int FFT_SIZE    = 16;
  localparam int WORD_SIZE   = 16;
  localparam int DATA_LENGTH = 8;
  localparam int FFT_TIMEOUT = 64;
  localparam int TX_BYTES    = FFT_SIZE * WORD_SIZE / DATA_LENGTH;
  localparam int SEL_W       = $clog2(TX_BYTES);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fft_frame_sequencer_if #(.DATA_LENGTH(DATA_LENGTH), .SEL_W(SEL_W)) bus();

  fft_frame_sequencer #(
    .FFT_SIZE(FFT_SIZE), .WORD_SIZE(WORD_SIZE),
    .DATA_LENGTH(DATA_LENGTH), .FFT_TIMEOUT(FFT_TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus(bus)
  );

  // Free-running 100 MHz clock; rising edges fall at 5, 15, 25 ns and so on.
  always #5 clk = ~clk;

  // Expected-event queues filled by the model and drained by the monitor.
  int expLoadByte[$], expLoadLabel[$], expStartLabel[$];
  int expTxSel[$], expTxLabel[$], expDoneLabel[$];
  int expErrLabel[$], expOvrLabel[$];

  // Frame-level reference model state.
  typedef enum {M_ACCEPT, M_FFT, M_TX} mphase_e;
  mphase_e mPhase = M_ACCEPT;
  int mCnt = 0, mStart = 0, mIdx = 0, mTxLabel = 0;
  bit mOvr = 0;

  int  monLabel;
  bit  prevErr = 0, prevOvr = 0;
  bit  aborted;

  function automatic int curLabel();
    return (int'($time) - 5) / 10;
  endfunction

  function automatic logic [63:0] outVec();
    return 64'({bus.o_fft_load, bus.o_fft_byte, bus.o_fft_start, bus.o_sel, bus.o_tx_en,
                bus.o_tx_start, bus.o_busy, bus.o_frame_done, bus.o_err_timeout,
                bus.o_rx_overrun});
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void noteOverrun(input int label);
    if (!mOvr) begin
      expOvrLabel.push_back(label);
      mOvr = 1;
    end
  endfunction

  // One rising edge of the reference model, fed with the inputs sampled at it.
  function automatic void modelStep(input int label, input bit rx, input logic [7:0] b,
                                    input bit fd, input bit td);
    case (mPhase)
      M_ACCEPT: begin
        if (rx) begin
          if (mCnt == 0) mOvr = 0;
          expLoadByte.push_back(int'(b));
          expLoadLabel.push_back(label);
          mCnt++;
          if (mCnt == FFT_SIZE) begin
            mPhase = M_FFT;
            mStart = label;
            mCnt   = 0;
            expStartLabel.push_back(label);
          end
        end
      end
      M_FFT: begin
        if (rx) noteOverrun(label);
        if (fd) begin
          mPhase   = M_TX;
          mIdx     = 0;
          mTxLabel = label + 1;
          expTxSel.push_back(0);
          expTxLabel.push_back(mTxLabel);
        end else if (label == mStart + FFT_TIMEOUT) begin
          expErrLabel.push_back(label);
          mPhase = M_ACCEPT;
        end
      end
      M_TX: begin
        if (rx) noteOverrun(label);
        if (td && label > mTxLabel) begin
          if (mIdx == TX_BYTES - 1) begin
            expDoneLabel.push_back(label);
            mPhase = M_ACCEPT;
          end else begin
            mIdx++;
            mTxLabel = label + 1;
            expTxSel.push_back(mIdx);
            expTxLabel.push_back(mTxLabel);
          end
        end
      end
      default: mPhase = M_ACCEPT;
    endcase
  endfunction

  // Drive one cycle of inputs, let the model see the edge, then return the strobes low.
  task automatic applyStimulus(input bit rx, input logic [7:0] b, input bit fd, input bit td);
    bus.i_rx_done  = rx;
    bus.i_rx_byte  = b;
    bus.i_fft_done = fd;
    bus.i_tx_done  = td;
    @(posedge clk);
    modelStep(curLabel(), rx, b, fd, td);
    #1;
    bus.i_rx_done  = 1'b0;
    bus.i_rx_byte  = '0;
    bus.i_fft_done = 1'b0;
    bus.i_tx_done  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic sendBytes(input int n, input bit randomBytes, input int gapMax,
                           input int spuriousAfter);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = randomBytes ? 8'($urandom_range(0, 255)) : 8'(i + 1);
      applyStimulus(1'b1, b, 1'b0, 1'b0);
      if (i + 1 == spuriousAfter) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      if (gapMax > 0 && i < n - 1) idle($urandom_range(0, gapMax));
    end
  endtask

  task automatic doReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_outputs", outVec(), 64'h0);
    expLoadByte.delete();  expLoadLabel.delete(); expStartLabel.delete();
    expTxSel.delete();     expTxLabel.delete();   expDoneLabel.delete();
    expErrLabel.delete();  expOvrLabel.delete();
    mPhase = M_ACCEPT;
    mCnt   = 0;
    mOvr   = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Transmitter stand-in: answers each start with a done after a random delay.
  task automatic serviceTx(input int respMin, input int respMax, input int overrunSel,
                           input int resetSel, output bit wasAborted);
    wasAborted = 0;
    for (int n = 0; n < TX_BYTES; n++) begin
      int w;
      int delay;
      int curSel;
      w = 0;
      while (!bus.o_tx_start && w < 12) begin
        idle(1);
        w++;
      end
      if (!bus.o_tx_start) begin
        checkOutput("tx_start_wait", 64'd0, 64'd1);
        return;
      end
      curSel = int'(bus.o_sel);
      if (curSel == resetSel) begin
        doReset();
        wasAborted = 1;
        return;
      end
      delay = $urandom_range(respMin, respMax);
      for (int k = 0; k < delay; k++)
        applyStimulus((curSel == overrunSel && k == 1), 8'hAA, 1'b0, 1'b0);
      checkOutput("sel_hold", 64'(bus.o_sel), 64'(mIdx));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    end
    idle(2);
  endtask

  // Monitor: on every DUT output event, pop the matching expectation and compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevErr = 0;
      prevOvr = 0;
    end else begin
      monLabel = curLabel();
      if (bus.o_fft_load) begin
        if (expLoadByte.size() == 0) checkOutput("unexpected_load", 64'd1, 64'd0);
        else begin
          checkOutput("load_byte", 64'(bus.o_fft_byte), 64'(expLoadByte.pop_front()));
          checkOutput("load_time", 64'(monLabel), 64'(expLoadLabel.pop_front()));
        end
      end
      if (bus.o_fft_start) begin
        if (expStartLabel.size() == 0) checkOutput("unexpected_start", 64'd1, 64'd0);
        else checkOutput("start_time", 64'(monLabel), 64'(expStartLabel.pop_front()));
      end
      if (bus.o_tx_start) begin
        checkOutput("tx_en_at_start", 64'(bus.o_tx_en), 64'd1);
        if (expTxSel.size() == 0) checkOutput("unexpected_tx_start", 64'd1, 64'd0);
        else begin
          checkOutput("tx_sel", 64'(bus.o_sel), 64'(expTxSel.pop_front()));
          checkOutput("tx_time", 64'(monLabel), 64'(expTxLabel.pop_front()));
        end
      end
      if (bus.o_frame_done) begin
        checkOutput("busy_at_frame_done", 64'(bus.o_busy), 64'd0);
        if (expDoneLabel.size() == 0) checkOutput("unexpected_frame_done", 64'd1, 64'd0);
        else checkOutput("frame_done_time", 64'(monLabel), 64'(expDoneLabel.pop_front()));
      end
      if (bus.o_err_timeout && !prevErr) begin
        if (expErrLabel.size() == 0) checkOutput("unexpected_timeout", 64'd1, 64'd0);
        else checkOutput("timeout_time", 64'(monLabel), 64'(expErrLabel.pop_front()));
      end
      if (bus.o_rx_overrun && !prevOvr) begin
        if (expOvrLabel.size() == 0) checkOutput("unexpected_overrun", 64'd1, 64'd0);
        else checkOutput("overrun_time", 64'(monLabel), 64'(expOvrLabel.pop_front()));
      end
      prevErr = bus.o_err_timeout;
      prevOvr = bus.o_rx_overrun;
    end
  end

  // Hard stop in case something wedges the main sequence.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main scenario sequence.
  initial begin
    bus.i_rx_done  = 1'b0;
    bus.i_rx_byte  = '0;
    bus.i_fft_done = 1'b0;
    bus.i_tx_done  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_state", outVec(), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] nominal frame");
    sendBytes(FFT_SIZE, 1'b0, 0, 0);
    idle(19);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    serviceTx(5, 5, -1, -1, aborted);
    checkOutput("busy_after_frame", 64'(bus.o_busy), 64'd0);

    $display("[TB] fft timeout");
    sendBytes(FFT_SIZE, 1'b1, 1, 0);
    idle(FFT_TIMEOUT + 4);
    checkOutput("err_after_timeout", 64'(bus.o_err_timeout), 64'd1);
    checkOutput("busy_after_timeout", 64'(bus.o_busy), 64'd0);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    checkOutput("err_cleared", 64'(bus.o_err_timeout), 64'd0);
    sendBytes(FFT_SIZE - 1, 1'b1, 0, 0);
    idle(10);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    serviceTx(5, 5, -1, -1, aborted);

    $display("[TB] overrun during transmit");
    sendBytes(FFT_SIZE, 1'b1, 0, 0);
    idle(5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    serviceTx(5, 5, 7, -1, aborted);
    checkOutput("overrun_sticky", 64'(bus.o_rx_overrun), 64'd1);

    $display("[TB] reset mid-send");
    sendBytes(FFT_SIZE, 1'b1, 0, 0);
    idle(3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    serviceTx(5, 5, -1, 5, aborted);
    checkOutput("reset_abort_taken", 64'(aborted), 64'd1);
    sendBytes(FFT_SIZE, 1'b1, 0, 0);
    idle(4);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    serviceTx(3, 3, -1, -1, aborted);

    $display("[TB] spurious strobes");
    sendBytes(FFT_SIZE, 1'b1, 0, 3);
    idle(2);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    idle(5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    serviceTx(2, 4, -1, -1, aborted);

    $display("[TB] done on the expiry cycle");
    sendBytes(FFT_SIZE, 1'b1, 0, 0);
    idle(FFT_TIMEOUT - 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    serviceTx(1, 3, -1, -1, aborted);
    checkOutput("err_stays_low", 64'(bus.o_err_timeout), 64'd0);

    $display("[TB] random frames");
    repeat (4) begin
      sendBytes(FFT_SIZE, 1'b1, 2, 0);
      idle($urandom_range(0, FFT_TIMEOUT - 2));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      serviceTx(1, 6, -1, -1, aborted);
    end

    idle(3);
    checkOutput("pending_loads", 64'(expLoadByte.size()), 64'd0);
    checkOutput("pending_starts", 64'(expStartLabel.size()), 64'd0);
    checkOutput("pending_tx", 64'(expTxSel.size()), 64'd0);
    checkOutput("pending_frame_done", 64'(expDoneLabel.size()), 64'd0);
    checkOutput("pending_timeout", 64'(expErrLabel.size()), 64'd0);
    checkOutput("pending_overrun", 64'(expOvrLabel.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
